// File: rtl/ex_div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer sitting beside the ex stage.
// Restoring radix-2 divider that retires one quotient bit per cycle. While busy it holds the
// pipeline through stall_req. The result, rd and write enable come out for a single cycle.
module ex_div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            annul,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opv1,
  input  logic [XLEN-1:0] opv2,
  input  logic [4:0]      waddr_i,
  input  logic            we_i,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] wdata,
  output logic [4:0]      waddr_o,
  output logic            we_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] dvd_q;     // dividend magnitude; quotient bits shift in at the LSB
  logic [XLEN-1:0] dvs_q;     // divisor magnitude
  logic [XLEN-1:0] rem_q;     // partial remainder, always < divisor after restore
  logic [CW-1:0]   cnt_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            we_q;

  logic            is_signed;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] spec_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] res_quo;
  logic [XLEN-1:0] res_rem;
  logic [XLEN-1:0] result;

  // Operand decode at start: magnitudes and the two cases answered without iterating.
  always_comb begin
    is_signed = ~op[0];
    div_zero  = (opv2 == '0);
    ovf       = is_signed && (opv1 == {1'b1, {(XLEN-1){1'b0}}}) && (opv2 == '1);
    // Negating INT_MIN yields the same bit pattern, which is the correct unsigned magnitude.
    abs1      = (is_signed && opv1[XLEN-1]) ? -opv1 : opv1;
    abs2      = (is_signed && opv2[XLEN-1]) ? -opv2 : opv2;
    if (div_zero) begin
      spec_res = op[1] ? opv1 : '1;
    end else begin
      spec_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One restoring step plus the sign-corrected result of that step (used on the last one).
  always_comb begin
    rem_sh  = {rem_q, dvd_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_bit   = ~diff[XLEN];
    rem_nx  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {dvd_q[XLEN-2:0], q_bit};
    res_quo = neg_quo_q ? -quo_nx : quo_nx;
    res_rem = neg_rem_q ? -rem_nx : rem_nx;
    result  = op_q[1] ? res_rem : res_quo;
  end

  // Freeze the pipeline from the accepting cycle until the result is registered.
  always_comb begin
    stall_req = ((state_q == StIdle) && start && !annul) || (state_q == StRun);
  end

  // Sequencer with registered outputs; done and we_o default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      we_q      <= 1'b0;
      done      <= 1'b0;
      wdata     <= '0;
      waddr_o   <= '0;
      we_o      <= 1'b0;
    end else begin
      done <= 1'b0;
      we_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !annul) begin
            op_q    <= op;
            we_q    <= we_i;
            waddr_o <= waddr_i;
            cnt_q   <= CW'(XLEN);
            if (div_zero || ovf) begin
              state_q <= StDone;
              done    <= 1'b1;
              we_o    <= we_i;
              wdata   <= spec_res;
            end else begin
              state_q   <= StRun;
              dvd_q     <= abs1;
              dvs_q     <= abs2;
              rem_q     <= '0;
              neg_quo_q <= is_signed && (opv1[XLEN-1] ^ opv2[XLEN-1]);
              neg_rem_q <= is_signed && opv1[XLEN-1];
            end
          end
        end
        StRun: begin
          if (annul) begin
            state_q <= StIdle;
          end else begin
            dvd_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= StDone;
              done    <= 1'b1;
              we_o    <= we_q;
              wdata   <= result;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
